// File: rtl/alu_secuencial.sv
// Multi-cycle ALU: logic, add/sub and compare in one cycle; shift-add MUL and restoring DIV run iteratively.
// Latency: single-cycle ops give done 1 edge after start; MUL/DIV give done 33 edges after start.
// Backpressure: start is accepted only in IDLE/DONE; start while busy is dropped, never queued.
module alu_secuencial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOP = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Iteration registers. MUL uses acc/mcand/mplr; DIV uses rem/quo and the latched divisor.
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] b_lat;

  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic [CW-1:0]    cnt_dec;
  logic             last_iter;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] single_res;

  // Single-cycle operations; unlisted codes fall back to ADD.
  function automatic logic [WIDTH-1:0] alu_1c(input logic [3:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOP:  r = '0;
      default: r = a + b;
    endcase
    return r;
  endfunction

  // DONE behaves like IDLE for acceptance so back-to-back ops need no bubble.
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign is_mul    = (sel == OP_MUL);
  assign is_div    = (sel == OP_DIV);
  assign cnt_dec   = cnt - CW'(1);
  assign last_iter = (cnt_dec == '0);

  assign busy = (state == MUL) || (state == DIV);
  assign done = (state == DONE);

  // One shift-add step and one restoring-division step, evaluated every cycle.
  always_comb begin
    acc_nxt    = mplr[0] ? (acc + mcand) : acc;
    rem_sh     = {rem, quo[WIDTH-1]};
    // rem_sh < 2*B whenever it matters, so the low WIDTH bits of the difference are exact.
    div_ge     = (rem_sh >= {1'b0, b_lat});
    rem_nxt    = div_ge ? (rem_sh[WIDTH-1:0] - b_lat) : rem_sh[WIDTH-1:0];
    quo_nxt    = {quo[WIDTH-2:0], div_ge};
    single_res = alu_1c(sel, A, B);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (is_mul)      state_nxt = MUL;
          else if (is_div) state_nxt = DIV;
          else             state_nxt = DONE;
        end else if (state == DONE) begin
          state_nxt = IDLE;
        end
      end
      MUL, DIV: begin
        if (last_iter) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latching, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplr        <= '0;
      rem         <= '0;
      quo         <= '0;
      b_lat       <= '0;
      result      <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= 1'b0;
      b_lat       <= B;
      if (is_mul) begin
        cnt   <= CW'(WIDTH);
        acc   <= '0;
        mcand <= A;
        mplr  <= B;
      end else if (is_div) begin
        cnt <= CW'(WIDTH);
        rem <= '0;
        quo <= A;
      end else begin
        result <= single_res;
        zero   <= (single_res == '0);
      end
    end else if (state == MUL) begin
      cnt   <= cnt_dec;
      acc   <= acc_nxt;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      if (last_iter) begin
        result <= acc_nxt;
        zero   <= (acc_nxt == '0);
      end
    end else if (state == DIV) begin
      cnt <= cnt_dec;
      rem <= rem_nxt;
      quo <= quo_nxt;
      if (last_iter) begin
        result      <= quo_nxt;
        zero        <= (quo_nxt == '0);
        div_by_zero <= (b_lat == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed self-checking bench for alu_secuencial with hand-computed expected values.
// Latency: measures edges from start to done for every operation.
// Backpressure: drives a start while busy and from the done cycle to cover both acceptance rules.
module tb_alu_secuencial;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  sel;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_checks = 0;
  int n_errors = 0;
  int overlap  = 0;

  alu_secuencial #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sel         (sel),
    .A           (A),
    .B           (B),
    .result      (result),
    .zero        (zero),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done && busy) overlap++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge. Drives one start, then returns at the negedge of the done cycle.
  // lat counts edges from the start edge up to the edge that raised done.
  // If inject > 0, an ADD start is driven in the cycle after edge number inject.
  task automatic run_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                        input int inject, output int lat, output logic first_busy);
    bit fin;
    bit first;
    start = 1'b1; sel = s; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0; sel = 4'b0010; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
    lat = 1; fin = 0; first = 1; first_busy = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (first) first_busy = busy;
      first = 0;
      if (done) begin
        fin = 1;
      end else if (lat >= 100) begin
        check("timeout_waiting_done", 32'(lat), 32'd33);
        fin = 1;
      end else begin
        if (lat == inject) begin
          start = 1'b1; sel = 4'b0010; A = 32'd1; B = 32'd2;
        end
        @(posedge clk);
        lat++;
        #1;
        start = 1'b0;
      end
    end
  endtask

  int   lat;
  logic fb;
  int   done_seen;

  initial begin
    rst_n = 1'b1; start = 1'b0; sel = 4'b0; A = '0; B = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_result", result, 32'h0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0, lat, fb);
    check("add_wrap_res", result, 32'h0);
    check("add_wrap_zero", 32'(zero), 32'd1);
    check("add_lat", 32'(lat), 32'd1);
    check("add_busy", 32'(fb), 32'd0);
    @(negedge clk);

    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0, lat, fb);
    check("slt_neg_res", result, 32'd1);
    check("slt_neg_zero", 32'(zero), 32'd0);
    @(negedge clk);
    run_op(4'b0111, 32'd1, 32'hFFFF_FFFF, 0, lat, fb);
    check("slt_pos_res", result, 32'd0);
    check("slt_pos_zero", 32'(zero), 32'd1);
    @(negedge clk);
    run_op(4'b1111, 32'd5, 32'd7, 0, lat, fb);
    check("undef_add", result, 32'd12);
    @(negedge clk);
    run_op(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 0, lat, fb);
    check("and", result, 32'h0000_F000);
    @(negedge clk);
    run_op(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 0, lat, fb);
    check("or", result, 32'h0000_FFF0);
    @(negedge clk);
    run_op(4'b0110, 32'd5, 32'd7, 0, lat, fb);
    check("sub", result, 32'hFFFF_FFFE);
    @(negedge clk);
    run_op(4'b1000, 32'd3, 32'd4, 0, lat, fb);
    check("nop_res", result, 32'd0);
    check("nop_zero", 32'(zero), 32'd1);
    @(negedge clk);

    run_op(4'b0011, 32'd12345, 32'd6789, 0, lat, fb);
    check("mul_res", result, 32'd83810205);
    check("mul_lat", 32'(lat), 32'd33);
    check("mul_first_busy", 32'(fb), 32'd1);
    check("mul_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("mul_done_pulse", 32'(done), 32'd0);
    run_op(4'b0011, 32'h0001_0000, 32'h0001_0000, 0, lat, fb);
    check("mul_wrap_res", result, 32'd0);
    check("mul_wrap_zero", 32'(zero), 32'd1);
    @(negedge clk);

    run_op(4'b0100, 32'd100, 32'd7, 0, lat, fb);
    check("div_res", result, 32'd14);
    check("div_dbz", 32'(div_by_zero), 32'd0);
    check("div_lat", 32'(lat), 32'd33);
    @(negedge clk);
    run_op(4'b0100, 32'd5, 32'd0, 0, lat, fb);
    check("div0_res", result, 32'hFFFF_FFFF);
    check("div0_dbz", 32'(div_by_zero), 32'd1);
    check("div0_lat", 32'(lat), 32'd33);
    @(negedge clk);
    check("dbz_held", 32'(div_by_zero), 32'd1);
    run_op(4'b0010, 32'd2, 32'd3, 0, lat, fb);
    check("dbz_cleared", 32'(div_by_zero), 32'd0);
    check("add_after_div0", result, 32'd5);
    @(negedge clk);

    // ADD driven while the DIV is in flight must be dropped.
    run_op(4'b0100, 32'd100, 32'd7, 10, lat, fb);
    check("div_ign_res", result, 32'd14);
    check("div_ign_lat", 32'(lat), 32'd33);
    // New MUL accepted straight from the done cycle.
    run_op(4'b0011, 32'd3, 32'd4, 0, lat, fb);
    check("b2b_first_busy", 32'(fb), 32'd1);
    check("b2b_res", result, 32'd12);
    check("b2b_lat", 32'(lat), 32'd33);
    @(negedge clk);

    // Abort a MUL with reset after a few iterations.
    run_op(4'b0110, 32'd10, 32'd3, 0, lat, fb);
    @(negedge clk);
    start = 1'b1; sel = 4'b0011; A = 32'd9; B = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_result", result, 32'h0);
    check("abort_zero", 32'(zero), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);

    check("done_busy_overlap", 32'(overlap), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
